qupls4_mem_line_splitter: RTL and testbench
===========================================

Name: qupls4_mem_line_splitter

Overview:
Sits directly downstream of the Qupls4 address generator and upstream of the TLB/data-cache request port. Accepts one computed virtual address plus access size per handshake. Emits one or two cache-line-granular memory requests with 64-bit byte-select masks, splitting any access that crosses a 64-byte line boundary. Carries the ROB tag and store flag through so the memory pipeline can match responses.

Parameters:
ABITS, 64, address width (matches cpu_types_pkg::address_t)
TAGW, 8, ROB tag width
LINE_LG2, 6, log2 of line size in bytes; line = 64 bytes, sel width = 64

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
flush  in  1  synchronous discard of any pending access (pipeline flush)
in_v  in  1  agen result valid
in_rdy  out  1  splitter can accept
in_adr  in  ABITS  virtual byte address from agen
in_size  in  7  access size in bytes, legal 1..64
in_store  in  1  1=store, 0=load
in_tag  in  TAGW  ROB tag
out_v  out  1  request valid
out_rdy  in  1  downstream accepts
out_adr  out  ABITS  beat address
out_sel  out  64  byte selects within the line
out_store  out  1  copy of in_store
out_tag  out  TAGW  copy of in_tag
out_first  out  1  first beat of access
out_last  out  1  last beat of access
out_err  out  1  illegal size or address wrap

Behaviour:
- Reset (rst=0, async): state IDLE; out_v=0, out_adr=0, out_sel=0, out_store=0, out_tag=0, out_first=0, out_last=0, out_err=0. in_rdy=0 while rst asserted.
- States: IDLE (no beat held), BEAT1 (first beat presented), BEAT2 (second beat presented).
- Accept: transfer when in_v & in_rdy. in_rdy = ~flush & (state==IDLE | (out_v & out_last & out_rdy)). This allows back-to-back single-beat accesses at one per cycle.
- Latency: out_v rises the cycle after accept. All outputs are registered.
- On accept: off=in_adr[5:0]; end=in_adr+in_size-1; split = (in_adr[ABITS-1:6] != end[ABITS-1:6]).
- BEAT1 outputs:
  - out_adr=in_adr (unaligned).
  - n1 = split ? 64-off : in_size.
  - out_sel = ((1<<n1)-1) << off.
  - out_first=1; out_last=~split.
- BEAT2 outputs:
  - out_adr = {in_adr[ABITS-1:6]+1, 6'd0}.
  - out_sel = (1<<(in_size-n1))-1.
  - out_first=0, out_last=1.
  - Tag and store held from BEAT1.
- Transitions:
  - BEAT1 & out_rdy & split -> BEAT2.
  - BEAT1 & out_rdy & ~split -> IDLE, or BEAT1 if a new access is accepted the same cycle.
  - BEAT2 & out_rdy -> IDLE/BEAT1 by the same rule.
  - out_rdy=0 holds state and all outputs stable (valid must not drop, data must not change).
- Illegal size (in_size==0 or >64): single beat; out_adr=in_adr, out_sel=0, out_first=out_last=1, out_err=1.
- Address wrap: split with in_adr[ABITS-1:6] all ones. BEAT2 address wraps to 0 (mod 2^ABITS) and out_err=1 on BEAT2 only.
- Flush:
  - Next edge: state -> IDLE, out_v=0.
  - Overrides out_rdy and any same-cycle accept; in_rdy=0 during flush.
  - A flush during BEAT2 drops the second beat even if the first was already consumed.
- Reset mid-access: all state discarded immediately, no beat replayed after reset release.
- Size arithmetic: computed in 7 bits; 1<<64 handled as an all-ones mask (n1=64 when off=0 and size=64).

Test Plan:
- Aligned load: adr 0x1000, size 8, tag 0x15, out_rdy=1 -> next cycle one beat: adr 0x1000, sel 0x00000000000000FF, first=last=1, tag 0x15; out_v low following cycle.
- Line cross: adr 0x103C, size 8, store -> beat1 adr 0x103C sel 0xF000000000000000 first=1 last=0; beat2 adr 0x1040 sel 0x000000000000000F first=0 last=1; in_rdy low during BEAT1.
- Back-pressure and throughput: out_rdy=0 three cycles on beat1 of the split case -> outputs unchanged. Then 4 back-to-back aligned 8-byte accesses with out_rdy=1 -> one beat per cycle, no bubbles.
- Flush in BEAT2: split access, consume beat1, assert flush with beat2 valid -> out_v=0 next cycle, no beat2 transfer. in_v asserted during flush is not accepted.
- Errors: size 0 at adr 0x2000 -> single beat sel 0, err=1. Adr 0xFFFFFFFFFFFFFFFC size 8 -> beat2 adr 0x0, sel 0x0F, err=1.
- Async reset mid-split: drop rst between clock edges while in BEAT1 -> out_v=0 immediately. After release, idle with in_rdy=1 and no residual beat.

Source files
------------

// File: rtl/qupls4_mem_line_splitter.sv
// qupls4_mem_line_splitter: turns one agen access into one or two 64-byte-line
// requests with byte selects, carrying ROB tag and store flag through.
`timescale 1ns/1ps
`default_nettype none

module qupls4_mem_line_splitter #(
  parameter int ABITS    = 64,
  parameter int TAGW     = 8,
  parameter int LINE_LG2 = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_v,
  output logic             in_rdy,
  input  logic [ABITS-1:0] in_adr,
  input  logic [6:0]       in_size,
  input  logic             in_store,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_v,
  input  logic             out_rdy,
  output logic [ABITS-1:0] out_adr,
  output logic [63:0]      out_sel,
  output logic             out_store,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_first,
  output logic             out_last,
  output logic             out_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT1 = 2'd1;
  localparam logic [1:0] S_BEAT2 = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ABITS-1:0] adr_q, adr_d, b2_adr_q, b2_adr_d;
  logic [63:0]      sel_q, sel_d, b2_sel_q, b2_sel_d;
  logic             store_q, store_d, first_q, first_d, last_q, last_d;
  logic             err_q, err_d, b2_err_q, b2_err_d;
  logic [TAGW-1:0]  tag_q, tag_d;

  // n >= 64 yields a full-line mask so 1<<64 never has to be formed
  function automatic logic [63:0] f_mask(input logic [6:0] n);
    if (n[6]) return '1;
    else      return (64'd1 << n[5:0]) - 64'd1;
  endfunction

  logic                      accept;
  logic [LINE_LG2-1:0]       w_off;
  logic                      w_legal, w_split, w_wrap;
  logic [6:0]                w_n1, w_n2;
  logic [7:0]                w_reach;
  logic [ABITS-LINE_LG2-1:0] w_line_nxt;

  assign out_v  = (state_q != S_IDLE);
  assign in_rdy = rst & ~flush & ((state_q == S_IDLE) | (out_v & last_q & out_rdy));
  assign accept = in_v & in_rdy;

  // A legal access crosses the line iff offset + size runs past 64 bytes
  assign w_off      = in_adr[LINE_LG2-1:0];
  assign w_legal    = (in_size != 7'd0) && (in_size <= 7'd64);
  assign w_reach    = {2'b00, w_off} + {1'b0, in_size};
  assign w_split    = w_legal && (w_reach > 8'd64);
  assign w_n1       = w_split ? (7'd64 - {1'b0, w_off}) : in_size;
  assign w_n2       = in_size - w_n1;
  assign w_line_nxt = in_adr[ABITS-1:LINE_LG2] + 1'b1;
  assign w_wrap     = &in_adr[ABITS-1:LINE_LG2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      adr_q    <= '0;
      sel_q    <= '0;
      store_q  <= 1'b0;
      tag_q    <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      b2_adr_q <= '0;
      b2_sel_q <= '0;
      b2_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      store_q  <= store_d;
      tag_q    <= tag_d;
      first_q  <= first_d;
      last_q   <= last_d;
      err_q    <= err_d;
      b2_adr_q <= b2_adr_d;
      b2_sel_q <= b2_sel_d;
      b2_err_q <= b2_err_d;
    end
  end

  // In BEAT1 a cleared last flag means the access was split
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_BEAT1;
      S_BEAT1: if (out_rdy) state_d = !last_q ? S_BEAT2 : (accept ? S_BEAT1 : S_IDLE);
      S_BEAT2: if (out_rdy) state_d = accept ? S_BEAT1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    adr_d    = adr_q;
    sel_d    = sel_q;
    store_d  = store_q;
    tag_d    = tag_q;
    first_d  = first_q;
    last_d   = last_q;
    err_d    = err_q;
    b2_adr_d = b2_adr_q;
    b2_sel_d = b2_sel_q;
    b2_err_d = b2_err_q;
    if (accept) begin
      adr_d    = in_adr;
      sel_d    = w_legal ? (f_mask(w_n1) << w_off) : 64'd0;
      store_d  = in_store;
      tag_d    = in_tag;
      first_d  = 1'b1;
      last_d   = ~w_split;
      err_d    = ~w_legal;
      b2_adr_d = {w_line_nxt, {LINE_LG2{1'b0}}};
      b2_sel_d = f_mask(w_n2);
      b2_err_d = w_split & w_wrap;
    end else if ((state_q == S_BEAT1) && out_rdy && !last_q && !flush) begin
      adr_d   = b2_adr_q;
      sel_d   = b2_sel_q;
      first_d = 1'b0;
      last_d  = 1'b1;
      err_d   = b2_err_q;
    end
  end

  assign out_adr   = adr_q;
  assign out_sel   = sel_q;
  assign out_store = store_q;
  assign out_tag   = tag_q;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_qupls4_mem_line_splitter.sv
// Bench for qupls4_mem_line_splitter: vector table plus scoreboard of beats.
`timescale 1ns/1ps
`default_nettype none

module tb_qupls4_mem_line_splitter;

  logic        clk = 1'b0;
  logic        rst, flush, in_v, in_rdy, in_store, out_v, out_rdy;
  logic        out_store, out_first, out_last, out_err;
  logic [63:0] in_adr, out_adr, out_sel;
  logic [6:0]  in_size;
  logic [7:0]  in_tag, out_tag;

  qupls4_mem_line_splitter #(.ABITS(64), .TAGW(8), .LINE_LG2(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_v(in_v), .in_rdy(in_rdy), .in_adr(in_adr), .in_size(in_size),
    .in_store(in_store), .in_tag(in_tag),
    .out_v(out_v), .out_rdy(out_rdy), .out_adr(out_adr), .out_sel(out_sel),
    .out_store(out_store), .out_tag(out_tag), .out_first(out_first),
    .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] adr;
    logic [63:0] sel;
    logic [7:0]  tag;
    logic        store;
    logic        first;
    logic        last;
    logic        err;
  } beat_t;

  typedef struct {
    logic [63:0] adr;
    logic [6:0]  size;
    logic        store;
    logic [7:0]  tag;
    logic        two;
    logic [63:0] adr1;
    logic [63:0] sel1;
    logic        err1;
    logic [63:0] adr2;
    logic [63:0] sel2;
    logic        err2;
  } vec_t;

  beat_t sb[$];
  vec_t  tbl[11];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && out_v === 1'b1 && out_rdy === 1'b1 && flush === 1'b0) begin
      beat_t got, e;
      got = {out_adr, out_sel, out_tag, out_store, out_first, out_last, out_err};
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got adr %h sel %h expected no beat", out_adr, out_sel);
      end else begin
        e = sb.pop_front();
        chk("beat", {52'd0, got}, {52'd0, e});
      end
    end
  end

  task automatic send(input vec_t v, input bit drop2);
    beat_t b;
    bit    ok = 1'b0;
    in_v = 1'b1; in_adr = v.adr; in_size = v.size; in_store = v.store; in_tag = v.tag;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_rdy) begin ok = 1'b1; break; end
    end
    if (ok) begin
      b = '{adr:v.adr1, sel:v.sel1, tag:v.tag, store:v.store, first:1'b1, last:!v.two, err:v.err1};
      sb.push_back(b);
      if (v.two && !drop2) begin
        b = '{adr:v.adr2, sel:v.sel2, tag:v.tag, store:v.store, first:1'b0, last:1'b1, err:v.err2};
        sb.push_back(b);
      end
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_rdy %b expected 1", in_rdy);
      in_v = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    #1;
    chk("drain", 192'(sb.size()), 192'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   c0;
    tbl[0]  = '{adr:64'h1000, size:7'd8, store:1'b0, tag:8'h15, two:1'b0,
                adr1:64'h1000, sel1:64'h00000000000000FF, err1:1'b0, adr2:64'h0, sel2:64'h0, err2:1'b0};
    tbl[1]  = '{adr:64'h103C, size:7'd8, store:1'b1, tag:8'h21, two:1'b1,
                adr1:64'h103C, sel1:64'hF000000000000000, err1:1'b0, adr2:64'h1040, sel2:64'h000000000000000F, err2:1'b0};
    tbl[2]  = '{adr:64'h2000, size:7'd0, store:1'b0, tag:8'h33, two:1'b0,
                adr1:64'h2000, sel1:64'h0, err1:1'b1, adr2:64'h0, sel2:64'h0, err2:1'b0};
    tbl[3]  = '{adr:64'hFFFFFFFFFFFFFFFC, size:7'd8, store:1'b1, tag:8'h44, two:1'b1,
                adr1:64'hFFFFFFFFFFFFFFFC, sel1:64'hF000000000000000, err1:1'b0, adr2:64'h0, sel2:64'h000000000000000F, err2:1'b1};
    tbl[4]  = '{adr:64'h3000, size:7'd64, store:1'b0, tag:8'h55, two:1'b0,
                adr1:64'h3000, sel1:64'hFFFFFFFFFFFFFFFF, err1:1'b0, adr2:64'h0, sel2:64'h0, err2:1'b0};
    tbl[5]  = '{adr:64'h3001, size:7'd64, store:1'b1, tag:8'h66, two:1'b1,
                adr1:64'h3001, sel1:64'hFFFFFFFFFFFFFFFE, err1:1'b0, adr2:64'h3040, sel2:64'h1, err2:1'b0};
    tbl[6]  = '{adr:64'h303F, size:7'd1, store:1'b0, tag:8'h77, two:1'b0,
                adr1:64'h303F, sel1:64'h8000000000000000, err1:1'b0, adr2:64'h0, sel2:64'h0, err2:1'b0};
    tbl[7]  = '{adr:64'h303F, size:7'd2, store:1'b1, tag:8'h88, two:1'b1,
                adr1:64'h303F, sel1:64'h8000000000000000, err1:1'b0, adr2:64'h3040, sel2:64'h1, err2:1'b0};
    tbl[8]  = '{adr:64'h4005, size:7'd65, store:1'b0, tag:8'h99, two:1'b0,
                adr1:64'h4005, sel1:64'h0, err1:1'b1, adr2:64'h0, sel2:64'h0, err2:1'b0};
    tbl[9]  = '{adr:64'h4010, size:7'd16, store:1'b1, tag:8'hAA, two:1'b0,
                adr1:64'h4010, sel1:64'h00000000FFFF0000, err1:1'b0, adr2:64'h0, sel2:64'h0, err2:1'b0};
    tbl[10] = '{adr:64'h4FF8, size:7'd16, store:1'b0, tag:8'hBB, two:1'b1,
                adr1:64'h4FF8, sel1:64'hFF00000000000000, err1:1'b0, adr2:64'h5000, sel2:64'h00000000000000FF, err2:1'b0};

    rst = 1'b1; flush = 1'b0; in_v = 1'b0; in_adr = '0; in_size = '0;
    in_store = 1'b0; in_tag = '0; out_rdy = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("reset_outputs", 192'({out_v, out_adr, out_sel, out_store, out_tag, out_first, out_last, out_err}), 192'd0);
    chk("reset_in_rdy", 192'(in_rdy), 192'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("idle_in_rdy", 192'(in_rdy), 192'd1);

    // single aligned load: one beat, then out_v drops
    @(posedge clk); #1;
    out_rdy = 1'b1;
    send(tbl[0], 1'b0);
    in_v = 1'b0;
    @(negedge clk);
    chk("aligned_out_v", 192'(out_v), 192'd1);
    @(negedge clk);
    chk("aligned_out_v_drop", 192'(out_v), 192'd0);

    // split access held under back-pressure
    @(posedge clk); #1;
    out_rdy = 1'b0;
    send(tbl[1], 1'b0);
    in_v = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold", 192'({out_v, in_rdy, out_adr, out_sel, out_first, out_last}),
          192'({1'b1, 1'b0, 64'h103C, 64'hF000000000000000, 1'b1, 1'b0}));
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("beat1_split_in_rdy", 192'(in_rdy), 192'd0);
    drain();

    foreach (tbl[i]) send(tbl[i], 1'b0);
    in_v = 1'b0;
    drain();

    // four aligned accesses must take exactly four cycles
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      v = '{adr:64'h6000 + 64'(k) * 64'h40, size:7'd8, store:1'b0, tag:8'hC0 + 8'(k), two:1'b0,
            adr1:64'h6000 + 64'(k) * 64'h40, sel1:64'hFF, err1:1'b0, adr2:64'h0, sel2:64'h0, err2:1'b0};
      send(v, 1'b0);
    end
    in_v = 1'b0;
    chk("b2b_cycles", 192'(cyc - c0), 192'd4);
    drain();

    // flush while BEAT2 is presented drops it and blocks the new access
    send(tbl[10], 1'b1);
    in_v = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; in_v = 1'b1; in_adr = 64'h7000; in_size = 7'd8; in_tag = 8'hEE;
    @(negedge clk);
    chk("flush_in_rdy", 192'(in_rdy), 192'd0);
    chk("flush_beat2_valid", 192'(out_v), 192'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_v = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("flush_out_v", 192'(out_v), 192'd0);
    end
    drain();

    // asynchronous reset in the middle of a held split access
    @(posedge clk); #1;
    out_rdy = 1'b0;
    send(tbl[5], 1'b0);
    in_v = 1'b0;
    #3;
    chk("pre_reset_out_v", 192'(out_v), 192'd1);
    rst = 1'b0;
    #1;
    chk("async_reset_out", 192'({out_v, in_rdy, out_sel}), 192'd0);
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 192'({out_v, in_rdy}), 192'({1'b0, 1'b1}));
    out_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_no_replay", 192'(out_v), 192'd0);
    end
    chk("scoreboard_empty", 192'(sb.size()), 192'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
